// File: rtl/reg_pipe.sv
// Elastic register pipeline: DEPTH valid/data stages with ready/valid handshakes
// at both ends, bubble collapsing, flush and a live occupancy count.
module reg_pipe #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid;
   logic [WIDTH-1:0] data [DEPTH];
   logic [DEPTH-1:0] rdy;
   logic             rdy_acc;
   logic             in_fire;
   logic             out_fire;

   // A stage may load if it or any stage downstream of it is empty, or the sink drains.
   always_comb begin
      rdy_acc = out_ready;
      rdy     = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         rdy_acc = rdy_acc | ~valid[i];
         rdy[i]  = rdy_acc;
      end
   end

   assign in_ready  = rdy[0] & ~flush & ~rst;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = valid[DEPTH-1] & out_ready;
   assign out_valid = valid[DEPTH-1];
   assign out_data  = data[DEPTH-1];

   // Data registers only capture when a valid word actually moves in.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data[i] <= RESET_VAL;
         end
      end else if (flush) begin
         valid <= '0;
         count <= '0;
      end else begin
         if (rdy[0]) begin
            valid[0] <= in_fire;
            if (in_fire) begin
               data[0] <= in_data;
            end
         end
         for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
               valid[i] <= valid[i-1];
               if (valid[i-1]) begin
                  data[i] <= data[i-1];
               end
            end
         end
         if (in_fire && !out_fire) begin
            count <= count + CW'(1);
         end else if (!in_fire && out_fire) begin
            count <= count - CW'(1);
         end
      end
   end

endmodule
